// File: rtl/vram_write_scheduler_pkg.sv
// Shared text-grid constants and fill FSM encodings
// for the video_memory write scheduler.
package vram_write_scheduler_pkg;

   localparam int COLS       = 100;
   localparam int ROWS       = 60;
   localparam int XW         = 7;
   localparam int YW         = 6;
   localparam int ATTR_W     = 24;
   localparam int FIFO_DEPTH = 4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push while full
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/vram_write_scheduler.sv
// Owns the video_memory write port, arbitrating between
// buffered I2C cell writes and the full-screen fill engine.
module vram_write_scheduler #(
   parameter int COLS       = vram_write_scheduler_pkg::COLS,
   parameter int ROWS       = vram_write_scheduler_pkg::ROWS,
   parameter int XW         = vram_write_scheduler_pkg::XW,
   parameter int YW         = vram_write_scheduler_pkg::YW,
   parameter int ATTR_W     = vram_write_scheduler_pkg::ATTR_W,
   parameter int FIFO_DEPTH = vram_write_scheduler_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i2c_write,
   input  logic [XW-1:0]     i2c_x,
   input  logic [YW-1:0]     i2c_y,
   input  logic [ATTR_W-1:0] i2c_attr,
   input  logic              fill_start,
   input  logic [ATTR_W-1:0] fill_attr,
   input  logic              mem_ready,
   output logic              write,
   output logic [XW-1:0]     xtextwrite,
   output logic [YW-1:0]     ytextwrite,
   output logic [ATTR_W-1:0] value,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              overflow
);

   import vram_write_scheduler_pkg::*;

   localparam int EW = XW + YW + ATTR_W;
   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

   logic [0:0]        state;
   logic [XW-1:0]     cur_x;
   logic [YW-1:0]     cur_y;
   logic [ATTR_W-1:0] fill_val;

   logic              in_range;
   logic              req;
   logic              idle_grant;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              bypass;
   logic              drop;
   logic              last_cell;
   logic [EW-1:0]     fifo_dout;
   logic [XW-1:0]     head_x;
   logic [YW-1:0]     head_y;
   logic [ATTR_W-1:0] head_attr;

   assign in_range   = (i2c_x <= X_LAST) && (i2c_y <= Y_LAST);
   assign req        = i2c_write && in_range;
   assign idle_grant = (state == IDLE) && !fill_start && mem_ready;
   assign fifo_pop   = idle_grant && !fifo_empty;
   // Empty FIFO in IDLE: skip the buffer to get one-cycle latency.
   assign bypass     = idle_grant && fifo_empty && req;
   assign fifo_push  = req && !bypass && (!fifo_full || fifo_pop);
   assign drop       = req && fifo_full && !fifo_pop;
   assign last_cell  = (cur_x == X_LAST) && (cur_y == Y_LAST);

   assign {head_x, head_y, head_attr} = fifo_dout;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({i2c_x, i2c_y, i2c_attr}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         fill_val   <= '0;
         write      <= 1'b0;
         xtextwrite <= '0;
         ytextwrite <= '0;
         value      <= '0;
         fill_busy  <= 1'b0;
         fill_done  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         write     <= 1'b0;
         fill_done <= 1'b0;
         if (drop) overflow <= 1'b1;
         if (fill_start) begin
            state     <= FILL;
            fill_val  <= fill_attr;
            cur_x     <= '0;
            cur_y     <= '0;
            fill_busy <= 1'b1;
         end else if (state == FILL) begin
            fill_busy <= 1'b1;
            if (mem_ready) begin
               write      <= 1'b1;
               xtextwrite <= cur_x;
               ytextwrite <= cur_y;
               value      <= fill_val;
               if (last_cell) begin
                  fill_done <= 1'b1;
                  state     <= IDLE;
                  cur_x     <= '0;
                  cur_y     <= '0;
               end else if (cur_x == X_LAST) begin
                  cur_x <= '0;
                  cur_y <= cur_y + 1'b1;
               end else begin
                  cur_x <= cur_x + 1'b1;
               end
            end
         end else begin
            fill_busy <= 1'b0;
            if (fifo_pop) begin
               write      <= 1'b1;
               xtextwrite <= head_x;
               ytextwrite <= head_y;
               value      <= head_attr;
            end else if (bypass) begin
               write      <= 1'b1;
               xtextwrite <= i2c_x;
               ytextwrite <= i2c_y;
               value      <= i2c_attr;
            end
         end
      end
   end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Sole owner of the video_memory write port (write, xtextwrite, ytextwrite, value).
- Shares the port between two requesters:
  - the I2C slave: single-cell character_change pulses, buffered in a small FIFO;
  - a screen fill engine: clears or fills the whole text grid with one attribute word.
- Sits between i2c_slave and video_memory in vgade0.
- Issues writes only in cycles where the memory side grants a write slot.

Parameters:
- COLS, 100, text columns (800 px / 8 px per char).
- ROWS, 60, text rows.
- XW, 7, column index width (covers COLS-1).
- YW, 6, row index width (covers ROWS-1).
- ATTR_W, 24, width of one character+attribute word.
- FIFO_DEPTH, 4, I2C write buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- i2c_write  in  1  one-cycle request from i2c_slave (character_change).
- i2c_x  in  XW  column of the I2C write.
- i2c_y  in  YW  row of the I2C write.
- i2c_attr  in  ATTR_W  value of the I2C write.
- fill_start  in  1  one-cycle pulse: start (or restart) a full-screen fill.
- fill_attr  in  ATTR_W  fill value, sampled on fill_start.
- mem_ready  in  1  a write may be issued this cycle.
- write  out  1  one-cycle write strobe to video_memory.
- xtextwrite  out  XW  column of the current write.
- ytextwrite  out  YW  row of the current write.
- value  out  ATTR_W  data of the current write.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse, coincident with the last fill write.
- overflow  out  1  sticky: an I2C write was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, fill cursor at (0,0).
- Reset is synchronous and dominates every other input in the same cycle.
- Reset mid-fill aborts the fill: no fill_done pulse, and FIFO contents are discarded.
- All outputs are registered.
- FIFO push:
  - i2c_write pushes {x,y,attr} when the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and overflow is set; overflow clears only on reset.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- FSM state IDLE:
  - fill_start: latch fill_attr, set cursor (0,0), go to FILL, fill_busy=1 next cycle.
  - Otherwise, with mem_ready=1 and the FIFO not empty: pop the head entry; write=1 next cycle with that entry.
  - Minimum latency: i2c_write at cycle N into an empty FIFO gives write at N+1.
- FSM state FILL (strict priority over the FIFO):
  - Each cycle with mem_ready=1: write=1 next cycle at the cursor with the latched attr, then advance the cursor.
  - Cursor order: x+1; at x=COLS-1, wrap x to 0 and y+1.
  - Write (COLS-1, ROWS-1): fill_done=1 in the same cycle as that write, then return to IDLE; fill_busy drops after that cycle.
  - A full fill takes exactly COLS*ROWS granted cycles (6000 at defaults).
  - FIFO pushes continue during FILL; pops are stalled until IDLE.
  - Ordering rule: every I2C write accepted during a fill lands after the fill, so it is never overwritten by the fill.
  - fill_start during FILL: restart at (0,0) with the new fill_attr; no fill_done for the aborted fill.
- mem_ready=0: write=0. The cursor and FIFO hold; no request is lost apart from FIFO overflow.
- write is never high on two requesters' data at once; at most one write per cycle.
- Out-of-range I2C coordinates (x>=COLS or y>=ROWS): dropped at the FIFO input. They do not set overflow.

Decomposition:
- Constants for the shared package (existing constant.vh): COLS, ROWS, and the XW/YW/ATTR_W ranges, matching TEXTCOLS_RANGE, TEXTROWS_RANGE and CHARATTR_RANGE.
- Add fill FSM state encodings IDLE=0 and FILL=1 to the same package.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty).
- The arbitration FSM and fill cursor stay in vram_write_scheduler.

Test Plan:
- Reset: reset=1 for 2 cycles with i2c_write=1 -> all outputs 0, no write, FIFO empty after release.
- I2C single write: i2c_write at (5,3) attr 0x123456, mem_ready=1 -> next cycle write=1, x=5, y=3, value=0x123456.
- Overflow:
  - Setup: mem_ready=0, then 5 I2C writes.
  - Required: overflow=1 after the 5th write.
  - Then mem_ready=1: exactly 4 writes, in push order.
- Full fill: fill_start with attr 0x000020, mem_ready=1 ->
  - 6000 consecutive writes in raster order;
  - the 100th write at (99,0), the 101st at (0,1);
  - fill_done on the write at (99,59), fill_busy low afterwards.
- Fill vs I2C: I2C write (0,0) attr 0xAAAAAA at fill cycle 10 ->
  - it lands after fill_done;
  - the final contents of cell (0,0) are 0xAAAAAA.
- Stall and restart during a fill:
  - mem_ready toggled 1/0 -> the cursor advances only on granted cycles.
  - fill_start at cursor (40,2) -> the next write is at (0,0) with the new attr, and no fill_done for the first fill.
